// File: rtl/writeback_sequencer.sv
// Write-back sequencer: queues MEM/WB vector results and drains them onto the
// shared register-file write port, one lane per cycle, in ascending lane order.
module writeback_sequencer #(
    parameter int         WIDTH    = 16,
    parameter int         DEPTH    = 2,
    parameter logic [3:0] NULL_REG = 4'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             regWrite_in,
    input  logic [3:0]       rd_in,
    input  logic [3:0]       laneMask_in,
    input  logic [WIDTH-1:0] lane0_in,
    input  logic [WIDTH-1:0] lane1_in,
    input  logic [WIDTH-1:0] lane2_in,
    input  logic [WIDTH-1:0] lane3_in,
    output logic             regWriteWB,
    output logic [WIDTH-1:0] resultWB,
    output logic [3:0]       RdestW0,
    output logic [3:0]       RdestW1,
    output logic [3:0]       RdestW2,
    output logic [3:0]       RdestW3,
    output logic             busy
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    logic [3:0]       rd_mem   [DEPTH];
    logic [3:0]       mask_mem [DEPTH];
    logic [WIDTH-1:0] lane_mem [DEPTH][4];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    state_t           state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic             reg_write_q, reg_write_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       rdest_q [4];
    logic [3:0]       rdest_d [4];

    logic             push;
    logic             pop;
    logic             emit;
    logic [3:0]       head_mask;
    logic [3:0]       head_rd;
    logic [3:0]       cur_mask;
    logic [3:0]       rem_next;
    logic [1:0]       cur_lane;

    // Entries that would never write anything are consumed without being stored.
    assign ready_out = (count_q != FULL_CNT);
    assign push      = valid_in && ready_out && regWrite_in &&
                       (laneMask_in != 4'd0) && (rd_in != NULL_REG);

    assign head_mask = mask_mem[rd_ptr_q];
    assign head_rd   = rd_mem[rd_ptr_q];
    assign emit      = (count_q != '0);

    // rem_q holds the not-yet-written lanes of the head; zero means a fresh head.
    assign cur_mask  = (rem_q != 4'd0) ? rem_q : head_mask;
    assign cur_lane  = lowest_lane(cur_mask);
    assign rem_next  = cur_mask & ~(4'b0001 << cur_lane);
    assign pop       = emit && (rem_next == 4'd0);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rem_d       = rem_q;
        reg_write_d = 1'b0;
        result_d    = result_q;
        for (int k = 0; k < 4; k++) begin
            rdest_d[k] = NULL_REG;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE:    if (emit) state_d = WRITE;
            WRITE:   if (!emit) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The next entry's first lane follows the last lane of the previous one directly.
        if (emit) begin
            reg_write_d       = 1'b1;
            result_d          = lane_mem[rd_ptr_q][cur_lane];
            rdest_d[cur_lane] = head_rd;
            rem_d             = rem_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rem_q       <= 4'd0;
            reg_write_q <= 1'b0;
            result_q    <= '0;
            for (int k = 0; k < 4; k++) begin
                rdest_q[k] <= NULL_REG;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            reg_write_q <= reg_write_d;
            result_q    <= result_d;
            for (int k = 0; k < 4; k++) begin
                rdest_q[k] <= rdest_d[k];
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]      <= rd_in;
            mask_mem[wr_ptr_q]    <= laneMask_in;
            lane_mem[wr_ptr_q][0] <= lane0_in;
            lane_mem[wr_ptr_q][1] <= lane1_in;
            lane_mem[wr_ptr_q][2] <= lane2_in;
            lane_mem[wr_ptr_q][3] <= lane3_in;
        end
    end

    assign regWriteWB = reg_write_q;
    assign resultWB   = result_q;
    assign RdestW0    = rdest_q[0];
    assign RdestW1    = rdest_q[1];
    assign RdestW2    = rdest_q[2];
    assign RdestW3    = rdest_q[3];
    assign busy       = (count_q != '0) || (state_q == WRITE);

endmodule

// File: tb/tb_writeback_sequencer.sv
// Bench for writeback_sequencer: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations on the observed write stream.
module tb_writeback_sequencer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic        regWrite_in;
    logic [3:0]  rd_in;
    logic [3:0]  laneMask_in;
    logic [15:0] lane_in [4];
    logic        regWriteWB;
    logic [15:0] resultWB;
    logic [3:0]  rdw0, rdw1, rdw2, rdw3;
    logic        busy;

    writeback_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NULL_REG(4'd0)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .regWrite_in(regWrite_in), .rd_in(rd_in), .laneMask_in(laneMask_in),
        .lane0_in(lane_in[0]), .lane1_in(lane_in[1]), .lane2_in(lane_in[2]), .lane3_in(lane_in[3]),
        .regWriteWB(regWriteWB), .resultWB(resultWB),
        .RdestW0(rdw0), .RdestW1(rdw1), .RdestW2(rdw2), .RdestW3(rdw3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][15:0] lanes;
        logic [3:0]       rd;
        logic [3:0]       rem;
    } ent_t;

    ent_t        q[$];
    logic        e_rw;
    logic [15:0] e_res;
    logic [3:0]  e_rd [4];
    logic        e_busy;
    bit          m_init = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    int          lg_n = 0;
    int          lg_lane [64];
    int          lg_rd   [64];
    int          lg_data [64];
    int          lg_nz   [64];
    int          lg_cyc  [64];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Reference: the queue holds every stored entry with its still-unwritten lanes.
    task automatic model_step();
        ent_t n;
        ent_t h;
        bit   rdy;
        int   k;
        if (!rst) begin
            q.delete();
            e_rw   = 1'b0;
            e_res  = 16'h0;
            for (int i = 0; i < 4; i++) e_rd[i] = 4'd0;
            e_busy = 1'b0;
            m_init = 1'b1;
        end else begin
            rdy  = (q.size() != DEPTH);
            e_rw = 1'b0;
            for (int i = 0; i < 4; i++) e_rd[i] = 4'd0;
            if (q.size() != 0) begin
                h = q[0];
                k = 0;
                for (int j = 3; j >= 0; j--) if (h.rem[j]) k = j;
                e_rw    = 1'b1;
                e_res   = h.lanes[k];
                e_rd[k] = h.rd;
                h.rem[k] = 1'b0;
                if (h.rem == 4'd0) void'(q.pop_front());
                else q[0] = h;
            end
            if (valid_in && rdy && regWrite_in && laneMask_in != 4'd0 && rd_in != 4'd0) begin
                for (int i = 0; i < 4; i++) n.lanes[i] = lane_in[i];
                n.rd  = rd_in;
                n.rem = laneMask_in;
                q.push_back(n);
            end
            e_busy = (q.size() != 0) || e_rw;
        end
    endtask

    task automatic compare();
        logic [3:0] got [4];
        int nz;
        int ln;
        got[0] = rdw0; got[1] = rdw1; got[2] = rdw2; got[3] = rdw3;
        check("regWriteWB", 32'(regWriteWB), 32'(e_rw));
        check("resultWB", 32'(resultWB), 32'(e_res));
        for (int k = 0; k < 4; k++) check($sformatf("RdestW%0d", k), 32'(got[k]), 32'(e_rd[k]));
        check("busy", 32'(busy), 32'(e_busy));
        check("ready_out", 32'(ready_out), 32'(q.size() != DEPTH));
        if (regWriteWB === 1'b1 && lg_n < 64) begin
            nz = 0;
            ln = 0;
            for (int k = 0; k < 4; k++) if (got[k] != 4'd0) begin nz++; ln = k; end
            lg_lane[lg_n] = ln;
            lg_rd[lg_n]   = int'(got[ln]);
            lg_data[lg_n] = int'(resultWB);
            lg_nz[lg_n]   = nz;
            lg_cyc[lg_n]  = cyc;
            lg_n++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (m_init) compare();
    endtask

    task automatic push(input bit rw, input logic [3:0] rd, input logic [3:0] m,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, output int waits);
        bit acc;
        valid_in = 1'b1; regWrite_in = rw; rd_in = rd; laneMask_in = m;
        lane_in[0] = a; lane_in[1] = b; lane_in[2] = c; lane_in[3] = d;
        waits = 0;
        do begin
            acc = ready_out;
            tick();
            if (!acc) waits++;
        end while (!acc && waits < 40);
        if (!acc) check("push_timeout", 32'(acc), 32'(1));
    endtask

    task automatic idle_in();
        valid_in = 1'b0; regWrite_in = 1'b0; rd_in = 4'd0; laneMask_in = 4'd0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 80) begin tick(); n++; end
        check("drain_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int b;
        int t0;
        logic [15:0] full_vals [4];
        full_vals[0] = 16'h1111; full_vals[1] = 16'h2222;
        full_vals[2] = 16'h3333; full_vals[3] = 16'h4444;

        rst = 1'b0;
        idle_in();
        for (int i = 0; i < 4; i++) lane_in[i] = 16'h0;
        tick();
        tick();
        check("rst_regWriteWB", 32'(regWriteWB), 32'(0));
        check("rst_resultWB", 32'(resultWB), 32'(0));
        check("rst_RdestW", 32'({rdw3, rdw2, rdw1, rdw0}), 32'(0));
        check("rst_ready_out", 32'(ready_out), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b1;
        tick();

        // Single full vector
        b = lg_n;
        push(1'b1, 4'd5, 4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444, w);
        t0 = cyc;
        idle_in();
        wait_idle();
        check("full_writes", 32'(lg_n - b), 32'(4));
        for (int k = 0; k < 4; k++) begin
            check("full_lane", 32'(lg_lane[b+k]), 32'(k));
            check("full_rd", 32'(lg_rd[b+k]), 32'(5));
            check("full_data", 32'(lg_data[b+k]), 32'(full_vals[k]));
            check("full_onehot", 32'(lg_nz[b+k]), 32'(1));
            check("full_timing", 32'(lg_cyc[b+k]), 32'(t0 + 1 + k));
        end
        check("full_hold_result", 32'(resultWB), 32'(16'h4444));

        // Sparse mask
        b = lg_n;
        push(1'b1, 4'd3, 4'b1010, 16'hDEAD, 16'hABCD, 16'hBEEF, 16'h00FF, w);
        t0 = cyc;
        idle_in();
        wait_idle();
        check("sparse_writes", 32'(lg_n - b), 32'(2));
        check("sparse_lane0", 32'(lg_lane[b]), 32'(1));
        check("sparse_rd0", 32'(lg_rd[b]), 32'(3));
        check("sparse_data0", 32'(lg_data[b]), 32'(16'hABCD));
        check("sparse_lane1", 32'(lg_lane[b+1]), 32'(3));
        check("sparse_rd1", 32'(lg_rd[b+1]), 32'(3));
        check("sparse_data1", 32'(lg_data[b+1]), 32'(16'h00FF));
        check("sparse_last", 32'(lg_cyc[b+1]), 32'(t0 + 2));

        // Back-pressure with three full vectors
        b = lg_n;
        push(1'b1, 4'd7, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, w);
        check("bp_push1_waits", 32'(w), 32'(0));
        push(1'b1, 4'd8, 4'b1111, 16'hB000, 16'hB001, 16'hB002, 16'hB003, w);
        check("bp_push2_waits", 32'(w), 32'(0));
        check("bp_full_ready", 32'(ready_out), 32'(0));
        push(1'b1, 4'd9, 4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003, w);
        check("bp_push3_waits", 32'(w), 32'(3));
        idle_in();
        wait_idle();
        check("bp_writes", 32'(lg_n - b), 32'(12));
        for (int i = 0; i < 12; i++) begin
            check("bp_lane", 32'(lg_lane[b+i]), 32'(i % 4));
            check("bp_rd", 32'(lg_rd[b+i]), 32'(7 + i / 4));
            check("bp_data", 32'(lg_data[b+i]), 32'(16'hA000 + (i / 4) * 16'h1000 + i % 4));
            if (i > 0) check("bp_contig", 32'(lg_cyc[b+i] - lg_cyc[b+i-1]), 32'(1));
        end

        // Filtered pushes
        b = lg_n;
        push(1'b0, 4'd6, 4'b1111, 16'h0101, 16'h0202, 16'h0303, 16'h0404, w);
        check("flt_rw0_waits", 32'(w), 32'(0));
        push(1'b1, 4'd0, 4'b1111, 16'h0505, 16'h0606, 16'h0707, 16'h0808, w);
        check("flt_rd0_waits", 32'(w), 32'(0));
        push(1'b1, 4'd6, 4'b0000, 16'h0909, 16'h0A0A, 16'h0B0B, 16'h0C0C, w);
        check("flt_m0_waits", 32'(w), 32'(0));
        idle_in();
        tick(); tick(); tick();
        check("flt_writes", 32'(lg_n - b), 32'(0));
        check("flt_ready", 32'(ready_out), 32'(1));
        check("flt_busy", 32'(busy), 32'(0));

        // Reset mid-drain
        b = lg_n;
        push(1'b1, 4'hA, 4'b1111, 16'h5A00, 16'h5A01, 16'h5A02, 16'h5A03, w);
        push(1'b1, 4'hB, 4'b1111, 16'h5B00, 16'h5B01, 16'h5B02, 16'h5B03, w);
        idle_in();
        w = 0;
        while (!(regWriteWB === 1'b1 && rdw2 === 4'hA) && w < 20) begin tick(); w++; end
        check("mid_lane2_seen", 32'(rdw2), 32'(4'hA));
        check("mid_pre_writes", 32'(lg_n - b), 32'(3));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_regWriteWB", 32'(regWriteWB), 32'(0));
        check("mid_busy", 32'(busy), 32'(0));
        check("mid_ready", 32'(ready_out), 32'(1));
        b = lg_n;
        repeat (10) tick();
        check("mid_no_writes", 32'(lg_n - b), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
